// File: rtl/simd_mem_subsystem.sv
// simd_mem_subsystem: run-time loadable IMEM/DMEM subsystem with run controller for the SIMD core
//  Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start, abort          run control pulses
//   ext_in                NUM_IN input words snapshotted into DMEM[0..NUM_IN-1] on start
//   prog_valid/ready/addr/data   IMEM write port, accepted outside RUN
//   host_raddr/rdata      host DMEM read port, 1-cycle latency
//   busy, done, timeout, cycle_cnt   run status
//   core_rst              core reset, high unless RUN
//   core_iaddr/inst       core fetch port, 1-cycle latency
//   core_daddr/dR/dW/wdata/rdata   core data port, 1-cycle read latency
//   core_done             core halt indication
//   wr_mon_valid/addr/data   registered monitor of committed core writes
module simd_mem_subsystem #(
   parameter int          INST_W     = 18,
   parameter int          DATA_W     = 16,
   parameter int          IADDR_W    = 10,
   parameter int          DADDR_W    = 10,
   parameter int          NUM_IN     = 3,
   parameter logic [31:0] MAX_CYCLES = 32'd0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [NUM_IN*DATA_W-1:0] ext_in,
   input  logic                     prog_valid,
   output logic                     prog_ready,
   input  logic [IADDR_W-1:0]       prog_addr,
   input  logic [INST_W-1:0]        prog_data,
   input  logic [DADDR_W-1:0]       host_raddr,
   output logic [DATA_W-1:0]        host_rdata,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic [31:0]              cycle_cnt,
   output logic                     core_rst,
   input  logic [IADDR_W-1:0]       core_iaddr,
   output logic [INST_W-1:0]        core_inst,
   input  logic [DADDR_W-1:0]       core_daddr,
   input  logic                     core_dR,
   input  logic                     core_dW,
   input  logic [DATA_W-1:0]        core_wdata,
   output logic [DATA_W-1:0]        core_rdata,
   input  logic                     core_done,
   output logic                     wr_mon_valid,
   output logic [DADDR_W-1:0]       wr_mon_addr,
   output logic [DATA_W-1:0]        wr_mon_data
);
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
   state_t state, state_nx;
   logic [INST_W-1:0] imem [2**IADDR_W];
   logic [DATA_W-1:0] dmem [2**DADDR_W];
   logic run, go, we, pwe, wd;
   logic [31:0] cnt_inc;
   assign run        = state == RUN;
   assign go         = start && !abort && !run;
   assign we         = run && core_dR && core_dW;
   assign pwe        = prog_valid && !run;
   assign cnt_inc    = &cycle_cnt ? cycle_cnt : cycle_cnt + 32'd1;
   // watchdog looks at the count this cycle will produce, so the run stops after exactly MAX_CYCLES cycles
   assign wd         = MAX_CYCLES != 32'd0 && cnt_inc == MAX_CYCLES;
   assign busy       = run;
   assign done       = state == HALTED;
   assign core_rst   = !run;
   assign prog_ready = !run;
   always_comb begin
      state_nx = state;
      state_nx = abort ? IDLE : run ? ((core_done || wd) ? HALTED : RUN) : start ? RUN : state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         timeout      <= 1'b0;
         cycle_cnt    <= '0;
         core_inst    <= '0;
         core_rdata   <= '0;
         host_rdata   <= '0;
         wr_mon_valid <= 1'b0;
         wr_mon_addr  <= '0;
         wr_mon_data  <= '0;
      end else begin
         state        <= state_nx;
         host_rdata   <= dmem[host_raddr];
         wr_mon_valid <= we;
         timeout      <= (go || abort) ? 1'b0 : (run && !core_done && wd) ? 1'b1 : timeout;
         cycle_cnt    <= go ? '0 : run ? cnt_inc : cycle_cnt;
         if (we) begin
            wr_mon_addr <= core_daddr;
            wr_mon_data <= core_wdata;
         end
         if (run) core_inst <= imem[core_iaddr];
         if (run && core_dR && !core_dW) core_rdata <= dmem[core_daddr];
      end
   end
   // core writes only happen in RUN and the input snapshot only outside RUN, so they never collide
   always_ff @(posedge clk) begin
      if (pwe) imem[prog_addr] <= prog_data;
      if (we) dmem[core_daddr] <= core_wdata;
      if (go)
         for (int k = 0; k < NUM_IN; k++) dmem[DADDR_W'(k)] <= ext_in[k*DATA_W +: DATA_W];
   end
endmodule
